// File: rtl/mandelbrot_frame_scheduler.sv
// Frame sequencer: raster-scans every pixel, launches the iteration engine and writes one byte per pixel.
// Define MANDEL_PALETTE_EN to map escape counts through a 16-entry palette ROM instead of count[7:0].
module mandelbrot_frame_scheduler #(
    parameter int unsigned             H_PIX   = 640,
    parameter int unsigned             V_PIX   = 480,
    parameter int unsigned             COORD_W = 16,
    parameter logic [COORD_W-1:0]      X_START = 16'hE000,
    parameter logic [COORD_W-1:0]      Y_START = 16'hF000,
    parameter logic [COORD_W-1:0]      STEP    = 16'h000D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    output logic               ack,
    output logic               busy,
    input  logic [15:0]        r0,
    output logic               it_start,
    output logic [COORD_W-1:0] it_cx,
    output logic [COORD_W-1:0] it_cy,
    output logic [15:0]        it_max,
    input  logic               it_done,
    input  logic [15:0]        it_count,
    output logic               de_req,
    input  logic               de_ack,
    output logic [17:0]        de_addr,
    output logic [3:0]         de_nbyte,
    output logic [31:0]        de_data
);

    localparam int unsigned XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam logic [XW-1:0] XLast = XW'(H_PIX - 1);
    localparam logic [YW-1:0] YLast = YW'(V_PIX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StLaunch,
        StWait,
        StWrite,
        StNext
    } state_e;

    state_e             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic [15:0]        it_max_q, it_max_d;
    logic [19:0]        addr_q, addr_d;
    logic [7:0]         pix_q, pix_d;
    logic [7:0]         pix_byte;

`ifdef MANDEL_PALETTE_EN
    logic [7:0] palette_rom [16];

    for (genvar i = 0; i < 16; i++) begin : g_rom
        localparam logic [3:0] Idx = 4'(i);
        assign palette_rom[i] = {Idx, ~Idx};
    end

    assign pix_byte = (it_count == it_max_q) ? 8'h00 : palette_rom[it_count[3:0]];
`else
    assign pix_byte = (it_count == it_max_q) ? 8'h00 : it_count[7:0];
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        it_max_d = it_max_q;
        addr_d   = addr_q;
        pix_d    = pix_q;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StAck;
            end
            StAck: begin
                it_max_d = (r0 == 16'd0) ? 16'd1 : r0;
                x_d      = '0;
                y_d      = '0;
                cx_d     = X_START;
                cy_d     = Y_START;
                addr_d   = '0;
                state_d  = StLaunch;
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (it_done) begin
                    pix_d   = pix_byte;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (de_ack) state_d = StNext;
            end
            StNext: begin
                // Last pixel leaves all counters untouched; the next ACK reloads them.
                if (x_q == XLast && y_q == YLast) begin
                    state_d = StIdle;
                end else begin
                    addr_d  = addr_q + 20'd1;
                    state_d = StLaunch;
                    if (x_q == XLast) begin
                        x_d  = '0;
                        cx_d = X_START;
                        y_d  = y_q + YW'(1);
                        cy_d = cy_q + STEP;
                    end else begin
                        x_d  = x_q + XW'(1);
                        cx_d = cx_q + STEP;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            it_max_q <= '0;
            addr_q   <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            it_max_q <= it_max_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
        end
    end

    assign ack      = (state_q == StAck);
    assign busy     = (state_q != StIdle);
    assign it_start = (state_q == StLaunch);
    assign de_req   = (state_q == StWrite);
    assign it_cx    = cx_q;
    assign it_cy    = cy_q;
    assign it_max   = it_max_q;
    assign de_addr  = addr_q[19:2];
    assign de_data  = {4{pix_q}};

    // Lane strobes are only asserted while a write is being offered.
    always_comb begin
        de_nbyte = 4'b1111;
        if (state_q == StWrite) begin
            unique case (addr_q[1:0])
                2'b00:   de_nbyte = 4'b1110;
                2'b01:   de_nbyte = 4'b1101;
                2'b10:   de_nbyte = 4'b1011;
                default: de_nbyte = 4'b0111;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Directed bench for mandelbrot_frame_scheduler on an 8x2 frame with a scoreboard of expected writes.
module tb_mandelbrot_frame_scheduler;

    localparam int unsigned H = 8;
    localparam int unsigned V = 2;
    localparam logic [15:0] XS = 16'hE000;
    localparam logic [15:0] YS = 16'hF000;
    localparam logic [15:0] ST = 16'h000D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        ack, busy, it_start, de_req;
    logic [15:0] r0 = 16'd16;
    logic [15:0] it_cx, it_cy, it_max;
    logic        it_done = 1'b0;
    logic [15:0] it_count = 16'd0;
    logic        de_ack = 1'b0;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic [31:0] de_data;

    mandelbrot_frame_scheduler #(
        .H_PIX(H), .V_PIX(V), .COORD_W(16), .X_START(XS), .Y_START(YS), .STEP(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy), .r0(r0),
        .it_start(it_start), .it_cx(it_cx), .it_cy(it_cy), .it_max(it_max),
        .it_done(it_done), .it_count(it_count), .de_req(de_req), .de_ack(de_ack),
        .de_addr(de_addr), .de_nbyte(de_nbyte), .de_data(de_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] addr;
        logic [3:0]  nbyte;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_assert = 0;
    int  n_fail = 0;
    int  n_acks = 0;
    int  n_writes = 0;
    int  pix_idx = 0;
    int  exp_max = 1;
    int  eng_count = 5;
    int  eng_lat = 3;
    int  ack_dly = 0;
    int  ack_wait = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int cnt, input int mx);
        if (cnt == mx) return 8'h00;
`ifdef MANDEL_PALETTE_EN
        return {cnt[3:0], ~cnt[3:0]};
`else
        return cnt[7:0];
`endif
    endfunction

    function automatic logic [3:0] exp_nbyte(input int p);
        case (p % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Iteration engine model: one-cycle done pulse eng_lat cycles after launch.
    always begin
        @(negedge clk);
        if (it_start && rst_n) begin
            repeat (eng_lat) @(negedge clk);
            it_done  = 1'b1;
            it_count = 16'(eng_count);
            @(negedge clk);
            it_done  = 1'b0;
        end
    end

    // Scoreboard push at launch, compare while a write is offered, pop on acceptance.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ack) begin
                pix_idx = 0;
                n_acks++;
                exp_max = (r0 == 16'd0) ? 1 : int'(r0);
            end
            if (it_start) begin
                wr_t e;
                int  x, y;
                x = pix_idx % H;
                y = pix_idx / H;
                check("it_cx", 64'(it_cx), 64'(16'(XS + 16'(x) * ST)));
                check("it_cy", 64'(it_cy), 64'(16'(YS + 16'(y) * ST)));
                check("it_max", 64'(it_max), 64'(exp_max));
                e.addr  = 18'(pix_idx / 4);
                e.nbyte = exp_nbyte(pix_idx);
                e.data  = {4{exp_byte(eng_count, exp_max)}};
                sb.push_back(e);
                pix_idx++;
            end
            if (de_req) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                    de_ack = 1'b1;
                end else begin
                    check("de_addr", 64'(de_addr), 64'(sb[0].addr));
                    check("de_nbyte", 64'(de_nbyte), 64'(sb[0].nbyte));
                    check("de_data", 64'(de_data), 64'(sb[0].data));
                    if (ack_wait == ack_dly) begin
                        de_ack = 1'b1;
                        void'(sb.pop_front());
                        n_writes++;
                    end else begin
                        de_ack = 1'b0;
                        ack_wait++;
                    end
                end
            end else begin
                de_ack   = 1'b0;
                ack_wait = 0;
            end
        end
    end

    task automatic start_frame();
        int t;
        @(negedge clk);
        req = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 20);
        check("ack_seen", 64'(ack), 64'd1);
        req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while (busy && t < bound) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", 64'(busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_frame(input int rv, input int cnt, input int dly);
        int w0;
        r0 = 16'(rv);
        eng_count = cnt;
        ack_dly = dly;
        w0 = n_writes;
        start_frame();
        wait_idle(3000);
        check("frame_writes", 64'(n_writes - w0), 64'(H * V));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, w0, t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_it_start", 64'(it_start), 64'd0);
        check("rst_de_req", 64'(de_req), 64'd0);
        check("rst_nbyte", 64'(de_nbyte), 64'hF);
        check("rst_data", 64'(de_data), 64'd0);
        check("rst_addr", 64'(de_addr), 64'd0);
        check("rst_cx", 64'(it_cx), 64'd0);
        check("rst_it_max", 64'(it_max), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Baseline frame, then count==max, then r0==0 clamp, then slow write port.
        run_frame(16, 5, 0);
        run_frame(16, 16, 0);
        run_frame(0, 1, 0);
        check("clamped_max", 64'(it_max), 64'd1);
        run_frame(16, 3, 5);

        // Request pulse while busy must not start another frame.
        a0 = n_acks;
        w0 = n_writes;
        r0 = 16'd16;
        eng_count = 7;
        ack_dly = 0;
        start_frame();
        repeat (20) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("no_ack_busy", 64'(ack), 64'd0);
        wait_idle(3000);
        check("pulse_acks", 64'(n_acks - a0), 64'd1);
        check("pulse_writes", 64'(n_writes - w0), 64'(H * V));

        // Held request restarts a second frame from address 0.
        a0 = n_acks;
        w0 = n_writes;
        eng_count = 9;
        @(negedge clk);
        req = 1'b1;
        t = 0;
        while (n_acks - a0 < 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        req = 1'b0;
        check("held_acks", 64'(n_acks - a0), 64'd2);
        wait_idle(3000);
        check("held_writes", 64'(n_writes - w0), 64'(2 * H * V));

        // Reset while a write is pending.
        ack_dly = 5;
        start_frame();
        t = 0;
        while (!de_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_write", 64'(de_req), 64'd1);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_de_req", 64'(de_req), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_nbyte", 64'(de_nbyte), 64'hF);
        @(negedge clk);
        rst_n    = 1'b1;
        de_ack   = 1'b0;
        ack_wait = 0;
        sb.delete();
        repeat (10) @(negedge clk);
        check("post_rst_de_req", 64'(de_req), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
